// File: rtl/therm_sort_ctrl_if.sv
//------------------------------------------------------------------------------
// therm_sort_ctrl_if : sorter control, capture and result handshake bundle. Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

interface therm_sort_ctrl_if #(
  parameter int W = 16
);
  localparam int CW = $clog2(W + 1);

  logic          start;
  logic          busy;
  logic          sort_p;
  logic [W-1:0]  sort_data;
  logic [CW-1:0] count;
  logic          valid;
  logic          ready;
  logic          err;

  modport master (
    output start, sort_data, ready,
    input  busy, sort_p, count, valid, err
  );

  modport slave (
    input  start, sort_data, ready,
    output busy, sort_p, count, valid, err
  );
endinterface

`default_nettype wire

// File: rtl/therm_sort_ctrl.sv
//------------------------------------------------------------------------------
// therm_sort_ctrl : precharge/sort sequencer with popcount capture; optional THERM_CHECK_EN bubble check. Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module therm_sort_ctrl #(
  parameter int SAMPLES       = 2,
  parameter int OSF           = 8,
  parameter int PRE_CYCLES    = 2,
  parameter int SETTLE_CYCLES = 4
) (
  input  wire logic         clk,
  input  wire logic         rst_n,
  therm_sort_ctrl_if.slave  bus
);
  localparam int W    = SAMPLES * OSF;
  localparam int CW   = $clog2(W + 1);
  localparam int MAXC = (PRE_CYCLES > SETTLE_CYCLES) ? PRE_CYCLES : SETTLE_CYCLES;
  localparam int TW   = $clog2(MAXC + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PRE  = 2'd1,
    SORT = 2'd2,
    OUT  = 2'd3
  } state_t;

  state_t        r_state;
  logic [TW-1:0] r_cnt;
  logic          r_busy;
  logic          r_sort_p;
  logic          r_valid;
  logic [CW-1:0] r_count;
  logic          r_err;
  logic [CW-1:0] w_pop;
  logic          w_err;

  always_comb begin
    w_pop = '0;
    for (int i = 0; i < W; i++) begin
      w_pop = w_pop + CW'(bus.sort_data[i]);
    end
  end

`ifdef THERM_CHECK_EN
  // A legal code is exactly the low w_pop bits set; a shift by W wraps to 0, giving all ones.
  logic [W-1:0] w_mask;
  always_comb begin
    w_mask = (W'(1) << w_pop) - W'(1);
    w_err  = (bus.sort_data != w_mask);
  end
`else
  always_comb begin
    w_err = 1'b0;
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= IDLE;
      r_cnt    <= '0;
      r_busy   <= 1'b0;
      r_sort_p <= 1'b1;
      r_valid  <= 1'b0;
      r_count  <= '0;
      r_err    <= 1'b0;
    end else begin
      if (r_cnt != TW'(MAXC)) begin
        r_cnt <= r_cnt + TW'(1);
      end
      case (r_state)
        IDLE: begin
          if (bus.start) begin
            r_state <= PRE;
            r_cnt   <= '0;
            r_busy  <= 1'b1;
          end
        end
        PRE: begin
          // The entry cycle loads the sorter; PRE_CYCLES further cycles of precharge follow.
          if (r_cnt == TW'(PRE_CYCLES)) begin
            r_state  <= SORT;
            r_cnt    <= '0;
            r_sort_p <= 1'b0;
          end
        end
        SORT: begin
          if (r_cnt == TW'(SETTLE_CYCLES - 1)) begin
            r_state  <= OUT;
            r_cnt    <= '0;
            r_sort_p <= 1'b1;
            r_valid  <= 1'b1;
            r_count  <= w_pop;
            r_err    <= w_err;
          end
        end
        OUT: begin
          if (bus.ready) begin
            r_valid <= 1'b0;
            r_cnt   <= '0;
            if (bus.start) begin
              r_state <= PRE;
            end else begin
              r_state <= IDLE;
              r_busy  <= 1'b0;
            end
          end
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign bus.busy   = r_busy;
  assign bus.sort_p = r_sort_p;
  assign bus.valid  = r_valid;
  assign bus.count  = r_count;
  assign bus.err    = r_err;
endmodule

`default_nettype wire
